// File: rtl/icap_pkg.sv
// Shared ICAPE2 command words, IPROG word table, sequencer states and byte bit-swap helper.
package icap_pkg;

    localparam logic [31:0] ICAP_DUMMY     = 32'hFFFF_FFFF;
    localparam logic [31:0] ICAP_SYNC      = 32'hAA99_5566;
    localparam logic [31:0] ICAP_NOOP      = 32'h2000_0000;
    localparam logic [31:0] ICAP_WR_WBSTAR = 32'h3002_0001;
    localparam logic [31:0] ICAP_WR_CMD    = 32'h3000_8001;
    localparam logic [31:0] ICAP_CMD_IPROG = 32'h0000_000F;

    localparam int ICAP_WORDS = 8;
    localparam int WBSTAR_IDX = 4;

    // Slot WBSTAR_IDX is never driven from this table; the latched warm-boot address is used there.
    localparam logic [31:0] ICAP_WORD_TABLE [ICAP_WORDS] = '{
        ICAP_DUMMY, ICAP_SYNC, ICAP_NOOP, ICAP_WR_WBSTAR,
        32'h0000_0000, ICAP_WR_CMD, ICAP_CMD_IPROG, ICAP_NOOP
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } icap_state_e;

    function automatic logic [31:0] bitswap32(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[b*8+i] = d[b*8+7-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/icap_word_rom.sv
// IPROG word lookup: table entry or latched WBSTAR, optionally byte bit-reversed.
// Latency: combinational.
// Backpressure: none; pure lookup.
module icap_word_rom
    import icap_pkg::*;
#(
    parameter bit BIT_SWAP = 1'b1
) (
    input  logic [2:0]  idx,
    input  logic [31:0] wbstar,
    output logic [31:0] word
);

    logic [31:0] raw;

    always_comb begin
        raw = ICAP_WORD_TABLE[idx];
        if (idx == 3'(WBSTAR_IDX)) begin
            raw = wbstar;
        end
        word = BIT_SWAP ? bitswap32(raw) : raw;
    end

endmodule

// File: rtl/icap_iprog_seq.sv
// Keyed ICAPE2 IPROG sequencer: streams the 8-word warm-boot sequence on an accepted request.
// Latency: first word registered on the cycle after the accepted req; one word per 1+GAP_CYCLES cycles.
// Backpressure: none; requests while busy are dropped silently, bad keys set sticky err.
module icap_iprog_seq
    import icap_pkg::*;
#(
    parameter logic [15:0] KEY            = 16'hB007,
    parameter int unsigned GAP_CYCLES     = 0,
    parameter bit          BIT_SWAP       = 1'b1,
    parameter logic [31:0] DEFAULT_WBSTAR = 32'h0000_0000
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        req,
    input  logic [15:0] req_key,
    input  logic        req_use_addr,
    input  logic [31:0] req_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        icap_csib,
    output logic        icap_rdwrb,
    output logic [31:0] icap_o
);

    localparam bit         HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(ICAP_WORDS - 1);

    icap_state_e state, state_nxt;
    logic [2:0]  idx_q, idx_nxt, issue_idx;
    logic [7:0]  gap_q, gap_nxt;
    logic [31:0] wbstar_q, wbstar_nxt;
    logic        err_q, err_nxt;
    logic        issue;
    logic        csib_q;
    logic [31:0] o_q;
    logic [31:0] rom_word;
    logic        key_ok;

    assign key_ok = (req_key == KEY);

    icap_word_rom #(
        .BIT_SWAP (BIT_SWAP)
    ) u_rom (
        .idx    (issue_idx),
        .wbstar (wbstar_q),
        .word   (rom_word)
    );

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx_q;
        gap_nxt    = gap_q;
        wbstar_nxt = wbstar_q;
        err_nxt    = err_q;
        issue      = 1'b0;
        issue_idx  = idx_q;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (key_ok) begin
                        wbstar_nxt = req_use_addr ? req_addr : DEFAULT_WBSTAR;
                        issue      = 1'b1;
                        issue_idx  = 3'd0;
                        idx_nxt    = 3'd0;
                        state_nxt  = ST_SEND;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (HAS_GAP) begin
                    gap_nxt   = 8'd0;
                    state_nxt = ST_GAP;
                end else if (idx_q == LAST_IDX) begin
                    state_nxt = ST_DONE;
                end else begin
                    issue     = 1'b1;
                    issue_idx = idx_q + 3'd1;
                    idx_nxt   = idx_q + 3'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (idx_q == LAST_IDX) begin
                        state_nxt = ST_DONE;
                    end else begin
                        issue     = 1'b1;
                        issue_idx = idx_q + 3'd1;
                        idx_nxt   = idx_q + 3'd1;
                        state_nxt = ST_SEND;
                    end
                end else begin
                    gap_nxt = gap_q + 8'd1;
                end
            end
            ST_DONE: begin
                // Absorbing: a good key cannot rearm, a bad key is still flagged.
                if (req && !key_ok) begin
                    err_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state    <= ST_IDLE;
            idx_q    <= 3'd0;
            gap_q    <= 8'd0;
            wbstar_q <= 32'h0;
            err_q    <= 1'b0;
            csib_q   <= 1'b1;
            o_q      <= 32'h0;
        end else begin
            state    <= state_nxt;
            idx_q    <= idx_nxt;
            gap_q    <= gap_nxt;
            wbstar_q <= wbstar_nxt;
            err_q    <= err_nxt;
            csib_q   <= ~issue;
            if (issue) begin
                o_q <= rom_word;
            end
        end
    end

    assign busy       = (state == ST_SEND) || (state == ST_GAP);
    assign done       = (state == ST_DONE);
    assign err        = err_q;
    assign icap_csib  = csib_q;
    assign icap_rdwrb = 1'b0;
    assign icap_o     = o_q;

endmodule

// File: tb/tb_icap_iprog_seq.sv
// Bench for icap_iprog_seq: three parameterisations share one stimulus stream, checked against a queue-based model.
module tb_icap_iprog_seq;

    localparam int N = 3;
    localparam bit SWV [N] = '{1'b0, 1'b1, 1'b0};
    localparam int GPV [N] = '{0, 0, 2};
    localparam logic [15:0] GOOD_KEY = 16'hB007;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [15:0] key = 16'h0;
    logic        use_addr = 1'b0;
    logic [31:0] addr = 32'h0;

    logic        busy_w [N];
    logic        done_w [N];
    logic        err_w [N];
    logic        csib_w [N];
    logic        rdwrb_w [N];
    logic [31:0] o_w [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        icap_iprog_seq #(
            .KEY            (GOOD_KEY),
            .GAP_CYCLES     (GPV[g]),
            .BIT_SWAP       (SWV[g]),
            .DEFAULT_WBSTAR (32'h0000_0000)
        ) u_dut (
            .axi_aclk     (clk),
            .axi_aresetn  (rst_n),
            .req          (req),
            .req_key      (key),
            .req_use_addr (use_addr),
            .req_addr     (addr),
            .busy         (busy_w[g]),
            .done         (done_w[g]),
            .err          (err_w[g]),
            .icap_csib    (csib_w[g]),
            .icap_rdwrb   (rdwrb_w[g]),
            .icap_o       (o_w[g])
        );
    end

    always #5 clk = ~clk;

    typedef struct packed {
        logic        csib;
        logic [31:0] o;
    } ent_t;

    ent_t        mq [N][$];
    logic        m_done [N];
    logic        m_err [N];
    logic [31:0] m_last [N];

    logic [31:0] wq [N][$];
    int          ws [N];
    int          bc [N];
    int          bs [N];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] ref_swap(input logic [31:0] d);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[i] = d[(i / 8) * 8 + 7 - (i % 8)];
        return r;
    endfunction

    function automatic logic [31:0] ref_word(input int w, input logic [31:0] wb);
        logic [31:0] tbl [8];
        tbl = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
                32'h00000000, 32'h30008001, 32'h0000000F, 32'h20000000};
        if (w == 4) return wb;
        return tbl[w];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            m_done[i] = 1'b0;
            m_err[i]  = 1'b0;
            m_last[i] = 32'h0;
        end
    endtask

    // Called right after each rising edge, with the inputs that edge sampled.
    task automatic model_edge();
        for (int i = 0; i < N; i++) begin
            bit was_busy;
            was_busy = (mq[i].size() > 0);
            if (was_busy) begin
                m_last[i] = mq[i][0].o;
                void'(mq[i].pop_front());
                if (mq[i].size() == 0) m_done[i] = 1'b1;
            end
            if (req && !was_busy) begin
                if (key != GOOD_KEY) begin
                    m_err[i] = 1'b1;
                end else if (!m_done[i]) begin
                    logic [31:0] wb, ow;
                    wb = use_addr ? addr : 32'h0;
                    for (int w = 0; w < 8; w++) begin
                        ow = SWV[i] ? ref_swap(ref_word(w, wb)) : ref_word(w, wb);
                        mq[i].push_back({1'b0, ow});
                        for (int k = 0; k < GPV[i]; k++) mq[i].push_back({1'b1, ow});
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            logic        eb, ec;
            logic [31:0] eo;
            eb = (mq[i].size() > 0);
            ec = eb ? mq[i][0].csib : 1'b1;
            eo = eb ? mq[i][0].o : m_last[i];
            checks++;
            if (csib_w[i] !== ec || o_w[i] !== eo || busy_w[i] !== eb ||
                done_w[i] !== m_done[i] || err_w[i] !== m_err[i] || rdwrb_w[i] !== 1'b0) begin
                errors++;
                $display("FAIL cycle_cmp inst%0d t=%0t: csib/o/busy/done/err/rdwrb got %b/%h/%b/%b/%b/%b required %b/%h/%b/%b/%b/0",
                         i, $time, csib_w[i], o_w[i], busy_w[i], done_w[i], err_w[i], rdwrb_w[i],
                         ec, eo, eb, m_done[i], m_err[i]);
            end
            if (csib_w[i] === 1'b0) wq[i].push_back(o_w[i]);
            if (busy_w[i] === 1'b1) bc[i]++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rst_n) compare_all();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    task automatic mark();
        for (int i = 0; i < N; i++) begin
            ws[i] = wq[i].size();
            bs[i] = bc[i];
        end
    endtask

    function automatic logic [31:0] got_word(input int i, input int k);
        if (wq[i].size() > ws[i] + k) return wq[i][ws[i] + k];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        model_reset();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic send_req(input logic [15:0] k, input logic ua, input logic [31:0] a);
        key      = k;
        use_addr = ua;
        addr     = a;
        req      = 1'b1;
        step();
        req = 1'b0;
    endtask

    initial begin
        logic [31:0] lit_a [8];
        lit_a = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000, 32'h30020001,
                  32'h00000000, 32'h30008001, 32'h0000000F, 32'h20000000};
        for (int i = 0; i < N; i++) begin
            bc[i] = 0;
            ws[i] = 0;
            bs[i] = 0;
        end
        model_reset();
        step();
        do_reset();
        step();

        for (int i = 0; i < N; i++)
            chk($sformatf("reset_state_inst%0d", i),
                {26'h0, csib_w[i], rdwrb_w[i], busy_w[i], done_w[i], err_w[i], |o_w[i]},
                {26'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Default address, plain and swapped words, gapped timing.
        mark();
        send_req(GOOD_KEY, 1'b0, 32'h1234_5678);
        repeat (30) step();
        for (int k = 0; k < 8; k++) chk($sformatf("raw_word%0d", k), got_word(0, k), lit_a[k]);
        chk("swap_word1", got_word(1, 1), 32'h5599AA66);
        chk("swap_word4_default", got_word(1, 4), 32'h00000000);
        chk("swap_word6", got_word(1, 6), 32'h000000F0);
        chk("nogap_busy_cycles", 32'(bc[0] - bs[0]), 32'd8);
        chk("gap_busy_cycles", 32'(bc[2] - bs[2]), 32'd24);
        chk("gap_word_count", 32'(wq[2].size() - ws[2]), 32'd8);
        for (int i = 0; i < N; i++)
            chk($sformatf("done_busy_inst%0d", i), {30'h0, done_w[i], busy_w[i]}, 32'h2);

        // Bad key, then a good request with a late address change and a repeat request while busy.
        do_reset();
        mark();
        send_req(16'h1234, 1'b1, 32'h0040_0000);
        repeat (3) step();
        for (int i = 0; i < N; i++)
            chk($sformatf("badkey_inst%0d", i),
                {29'h0, err_w[i], busy_w[i], csib_w[i]}, 32'h5);
        chk("badkey_no_words", 32'(wq[0].size() - ws[0]), 32'd0);
        mark();
        send_req(GOOD_KEY, 1'b1, 32'h0040_0000);
        addr = 32'hFFFF_0000;
        repeat (3) step();
        send_req(GOOD_KEY, 1'b1, 32'hFFFF_0000);
        repeat (30) step();
        chk("latched_addr_raw", got_word(0, 4), 32'h00400000);
        chk("latched_addr_swap", got_word(1, 4), 32'h00020000);
        chk("gap_busy_with_rereq", 32'(bc[2] - bs[2]), 32'd24);
        chk("gap_words_with_rereq", 32'(wq[2].size() - ws[2]), 32'd8);
        chk("err_sticky", {31'h0, err_w[2]}, 32'h1);

        // Reset during word 3.
        do_reset();
        mark();
        send_req(GOOD_KEY, 1'b0, 32'h0);
        repeat (3) step();
        chk("word3_showing", {31'h0, csib_w[0]}, 32'h0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < N; i++)
            chk($sformatf("async_csib_inst%0d", i), {31'h0, csib_w[i]}, 32'h1);
        step();
        step();
        rst_n = 1'b1;
        mark();
        repeat (10) step();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("post_reset_idle_inst%0d", i), {30'h0, busy_w[i], done_w[i]}, 32'h0);
            chk($sformatf("post_reset_nowords_inst%0d", i), 32'(wq[i].size() - ws[i]), 32'd0);
        end

        // Randomised episodes; each ends in a reset that often lands mid-sequence.
        for (int ep = 0; ep < 25; ep++) begin
            int n;
            do_reset();
            n = $urandom_range(20, 90);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    req      = 1'b1;
                    key      = ($urandom_range(0, 3) == 0) ? 16'($urandom) : GOOD_KEY;
                    use_addr = 1'($urandom);
                    addr     = $urandom;
                end else begin
                    req  = 1'b0;
                    addr = $urandom;
                end
                step();
            end
            req = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
